pipe_mux_n: RTL and testbench

//  Parametrised N-to-1 datapath multiplexer with a registered, valid/ready output stage.

---
 rtl/pipe_mux_n_if.sv | 39 +++
 rtl/pipe_mux_n.sv | 123 ++++++++++++
 tb/tb_pipe_mux_n.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_mux_n_if.sv
// Handshake/data bundle for pipe_mux_n.
//   master : request side (drives inputs, select, requests, consumer ready)
//   slave  : the multiplexer itself
// Signals:
//   in_bus      flattened inputs, input k = in_bus[k*WIDTH +: WIDTH]
//   sel         direct-mode select
//   in_valid    direct-mode request,  in_ready  request accepted
//   start_sweep sweep start pulse,    busy      sweep in progress
//   sweep_done  pulse with the final sweep beat
//   out_data / out_idx / sel_err      registered beat contents
//   out_valid / out_ready             output handshake
interface pipe_mux_n_if #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned SEL_W  = 3
);
  logic [NUM_IN*WIDTH-1:0] in_bus;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    start_sweep;
  logic                    busy;
  logic                    sweep_done;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_idx;
  logic                    sel_err;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_bus, sel, in_valid, start_sweep, out_ready,
    input  in_ready, busy, sweep_done, out_data, out_idx, sel_err, out_valid
  );

  modport slave (
    input  in_bus, sel, in_valid, start_sweep, out_ready,
    output in_ready, busy, sweep_done, out_data, out_idx, sel_err, out_valid
  );
endinterface

// File: rtl/pipe_mux_n.sv
// N-to-1 datapath multiplexer with a registered valid/ready output stage.
// Direct mode loads input[sel] per accepted request; sweep mode emits inputs
// 0..NUM_IN-1 in order from a single start_sweep pulse.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    pipe_mux_n_if slave modport (data, select, handshakes, status)
module pipe_mux_n #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned SEL_W  = 3
) (
  input logic          clk,
  input logic          reset,
  pipe_mux_n_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_idx_q, out_idx_d;
  logic             sel_err_q, sel_err_d;
  logic             out_valid_q, out_valid_d;
  logic             sweep_done_q, sweep_done_d;
  logic             busy_q, busy_d;

  logic             free;
  logic             in_ready;
  logic             accept;
  logic             sweep_load;
  logic             sweep_last;
  logic             sel_bad;
  logic [SEL_W-1:0] mux_idx;
  logic [WIDTH-1:0] mux_data;

  // Output register can take a new beat when empty or being drained this cycle.
  assign free       = !out_valid_q || bus.out_ready;
  assign in_ready   = (state_q == StIdle) && free && !bus.start_sweep;
  assign accept     = bus.in_valid && in_ready;
  assign sweep_load = (state_q == StSweep) && free;
  assign sweep_last = sweep_load && (32'(cnt_q) == NUM_IN - 1);
  assign sel_bad    = 32'(bus.sel) >= NUM_IN;
  assign mux_idx    = (state_q == StSweep) ? cnt_q : bus.sel;

  // Out-of-range indices match no input and yield zero.
  always_comb begin
    mux_data = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (mux_idx == SEL_W'(k)) mux_data = bus.in_bus[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    sel_err_d    = sel_err_q;
    out_valid_d  = out_valid_q;
    sweep_done_d = sweep_last;

    if (accept) begin
      out_data_d  = mux_data;
      out_idx_d   = bus.sel;
      sel_err_d   = sel_bad;
      out_valid_d = 1'b1;
    end else if (sweep_load) begin
      out_data_d  = mux_data;
      out_idx_d   = cnt_q;
      sel_err_d   = 1'b0;
      out_valid_d = 1'b1;
      if (sweep_last) begin
        cnt_d   = '0;
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q + SEL_W'(1);
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // start_sweep only matters in idle; in_ready is already low so no request is taken.
    if (state_q == StIdle && bus.start_sweep) begin
      state_d = StSweep;
      cnt_d   = '0;
    end

    busy_d = (state_d == StSweep);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      sel_err_q    <= 1'b0;
      out_valid_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      sel_err_q    <= sel_err_d;
      out_valid_q  <= out_valid_d;
      sweep_done_q <= sweep_done_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.busy       = busy_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.sel_err    = sel_err_q;
  assign bus.out_valid  = out_valid_q;

endmodule

// File: tb/tb_pipe_mux_n.sv
module tb_pipe_mux_n;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_mux_n_if #(.WIDTH(5), .NUM_IN(8), .SEL_W(3)) m ();
  pipe_mux_n_if #(.WIDTH(5), .NUM_IN(6), .SEL_W(3)) s ();

  pipe_mux_n #(.WIDTH(5), .NUM_IN(8), .SEL_W(3)) dut8 (.clk(clk), .reset(reset), .bus(m));
  pipe_mux_n #(.WIDTH(5), .NUM_IN(6), .SEL_W(3)) dut6 (.clk(clk), .reset(reset), .bus(s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load input k with (base + k).
  task automatic fill8(input int base);
    for (int k = 0; k < 8; k++) m.in_bus[k*5 +: 5] = 5'(base + k);
  endtask

  task automatic fill6(input int base);
    for (int k = 0; k < 6; k++) s.in_bus[k*5 +: 5] = 5'(base + k);
  endtask

  task automatic beat8(input string tag, input int data, input int idx);
    chk({tag, ".valid"}, 32'(m.out_valid), 32'd1);
    chk({tag, ".data"},  32'(m.out_data),  32'(data));
    chk({tag, ".idx"},   32'(m.out_idx),   32'(idx));
  endtask

  initial begin
    reset = 1'b1;
    m.in_bus = '0; m.sel = '0; m.in_valid = 1'b0; m.start_sweep = 1'b0; m.out_ready = 1'b1;
    s.in_bus = '0; s.sel = '0; s.in_valid = 1'b0; s.start_sweep = 1'b0; s.out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst.valid", 32'(m.out_valid), 0);
    chk("rst.data",  32'(m.out_data), 0);
    chk("rst.idx",   32'(m.out_idx), 0);
    chk("rst.busy",  32'(m.busy), 0);
    chk("rst.done",  32'(m.sweep_done), 0);
    chk("rst.err",   32'(m.sel_err), 0);
    chk("rst.ready", 32'(m.in_ready), 1);

    // 1: direct single beat
    fill8(0);
    m.in_bus[5*5 +: 5] = 5'h15;
    m.sel = 3'd5; m.in_valid = 1'b1;
    #1 chk("t1.in_ready", 32'(m.in_ready), 1);
    tick();
    m.in_valid = 1'b0;
    beat8("t1", 'h15, 5);
    chk("t1.err", 32'(m.sel_err), 0);
    tick();
    chk("t1.drain", 32'(m.out_valid), 0);
    chk("t1.hold",  32'(m.out_data), 'h15);

    // 2: back-to-back
    fill8(10);
    m.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m.sel = 3'(k);
      tick();
      beat8("t2", 10 + k, k);
    end
    m.in_valid = 1'b0;
    tick();
    chk("t2.drain", 32'(m.out_valid), 0);

    // 3: backpressure
    m.out_ready = 1'b0;
    m.sel = 3'd3; m.in_valid = 1'b1;
    tick();
    beat8("t3.load", 13, 3);
    m.sel = 3'd4;
    #1 chk("t3.in_ready_stall", 32'(m.in_ready), 0);
    fill8(20);
    tick();
    beat8("t3.stall1", 13, 3);
    tick();
    beat8("t3.stall2", 13, 3);
    m.out_ready = 1'b1;
    #1 chk("t3.in_ready_free", 32'(m.in_ready), 1);
    tick();
    beat8("t3.next", 24, 4);
    m.in_valid = 1'b0;
    tick();

    // 4: full sweep
    fill8(1);
    m.start_sweep = 1'b1;
    tick();
    m.start_sweep = 1'b0;
    chk("t4.busy", 32'(m.busy), 1);
    chk("t4.empty", 32'(m.out_valid), 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      beat8("t4", k + 1, k);
      chk("t4.done", 32'(m.sweep_done), 32'(k == 7));
      chk("t4.busy", 32'(m.busy), 32'(k != 7));
    end
    tick();
    chk("t4.end.valid", 32'(m.out_valid), 0);
    chk("t4.end.done",  32'(m.sweep_done), 0);
    chk("t4.end.busy",  32'(m.busy), 0);

    // 5a: sweep with a 4-cycle stall at beat 3
    m.start_sweep = 1'b1;
    tick();
    m.start_sweep = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      beat8("t5a", k + 1, k);
    end
    m.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      beat8("t5a.stall", 4, 3);
      chk("t5a.stall.done", 32'(m.sweep_done), 0);
    end
    m.out_ready = 1'b1;
    for (int k = 4; k < 8; k++) begin
      tick();
      beat8("t5a.resume", k + 1, k);
      chk("t5a.done", 32'(m.sweep_done), 32'(k == 7));
    end
    tick();

    // 5b: reset mid-sweep at beat 4
    m.start_sweep = 1'b1;
    tick();
    m.start_sweep = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      beat8("t5b", k + 1, k);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5b.valid", 32'(m.out_valid), 0);
      chk("t5b.busy",  32'(m.busy), 0);
      chk("t5b.done",  32'(m.sweep_done), 0);
      tick();
    end

    // 6a: collision, start_sweep beats in_valid
    m.sel = 3'd2; m.in_valid = 1'b1; m.start_sweep = 1'b1;
    #1 chk("t6.in_ready", 32'(m.in_ready), 0);
    tick();
    m.in_valid = 1'b0; m.start_sweep = 1'b0;
    chk("t6.dropped", 32'(m.out_valid), 0);
    chk("t6.busy", 32'(m.busy), 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      beat8("t6.sweep", k + 1, k);
      chk("t6.done", 32'(m.sweep_done), 32'(k == 7));
    end
    tick();

    // 6b: NUM_IN=6 out-of-range selects
    fill6(1);
    s.in_valid = 1'b1;
    s.sel = 3'd7;
    tick();
    chk("t6b.sel7.valid", 32'(s.out_valid), 1);
    chk("t6b.sel7.data",  32'(s.out_data), 0);
    chk("t6b.sel7.err",   32'(s.sel_err), 1);
    chk("t6b.sel7.idx",   32'(s.out_idx), 7);
    s.sel = 3'd5;
    tick();
    chk("t6b.sel5.data", 32'(s.out_data), 6);
    chk("t6b.sel5.err",  32'(s.sel_err), 0);
    s.sel = 3'd6;
    tick();
    chk("t6b.sel6.data", 32'(s.out_data), 0);
    chk("t6b.sel6.err",  32'(s.sel_err), 1);
    s.in_valid = 1'b0;
    s.start_sweep = 1'b1;
    tick();
    s.start_sweep = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t6b.sweep.data", 32'(s.out_data), 32'(k + 1));
      chk("t6b.sweep.idx",  32'(s.out_idx), 32'(k));
      chk("t6b.sweep.err",  32'(s.sel_err), 0);
      chk("t6b.sweep.done", 32'(s.sweep_done), 32'(k == 5));
    end
    tick();
    chk("t6b.end.busy", 32'(s.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
